// File: rtl/approx_mult_pkg.sv
// Shared types for the approximate-multiplier evaluation blocks:
// FSM encoding, radix-4 Booth digit encoding and default operand width.
package approx_mult_pkg;

    localparam int DEF_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_CMP  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        BD_ZERO = 3'd0,
        BD_P1   = 3'd1,
        BD_P2   = 3'd2,
        BD_M1   = 3'd5,
        BD_M2   = 3'd6
    } booth_e;

    // grp = {y[2i+1], y[2i], y[2i-1]}
    function automatic booth_e booth_digit(input logic [2:0] grp);
        booth_e d;
        case (grp)
            3'b001, 3'b010: d = BD_P1;
            3'b011:         d = BD_P2;
            3'b100:         d = BD_M2;
            3'b101, 3'b110: d = BD_M1;
            default:        d = BD_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_seq_mult.sv
// Iterative unsigned radix-4 Booth multiplier: one digit per cycle,
// W/2+1 digits; done is high in the cycle of the last digit.
module booth_r4_seq_mult
    import approx_mult_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int ND = W / 2 + 1;
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;
    localparam int AW = 2 * W + 2;
    localparam logic [CW-1:0] LAST = CW'(ND - 1);

    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] mc_q;
    logic signed [AW-1:0] pp;
    logic [W+1:0]         yb_q;
    logic                 prev_q;
    logic                 run_q;
    logic [CW-1:0]        cnt_q;
    booth_e               dig;

    assign dig = booth_digit({yb_q[1:0], prev_q});

    always_comb begin
        pp = '0;
        case (dig)
            BD_P1:   pp = mc_q;
            BD_P2:   pp = mc_q <<< 1;
            BD_M1:   pp = -mc_q;
            BD_M2:   pp = -(mc_q <<< 1);
            default: pp = '0;
        endcase
    end

    // mc_q carries x already aligned to the current digit weight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            mc_q   <= '0;
            yb_q   <= '0;
            prev_q <= 1'b0;
            run_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            acc_q  <= '0;
            mc_q   <= {{(AW - W){1'b0}}, x};
            yb_q   <= {2'b00, y};
            prev_q <= 1'b0;
            run_q  <= 1'b1;
            cnt_q  <= '0;
        end else if (run_q) begin
            acc_q  <= acc_q + pp;
            mc_q   <= mc_q <<< 2;
            yb_q   <= yb_q >> 2;
            prev_q <= yb_q[1];
            cnt_q  <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                run_q <= 1'b0;
            end
        end
    end

    assign done    = run_q && (cnt_q == LAST);
    assign product = acc_q[2*W-1:0];

endmodule

// File: rtl/approx_err_monitor.sv
// Streaming error-metric collector: exact product vs. approximate product,
// accumulating sample count, error count, summed and maximum error distance.
module approx_err_monitor
    import approx_mult_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic [2*W-1:0]   in_p,
    output logic [CNT_W-1:0] n_samples,
    output logic [CNT_W-1:0] n_err,
    output logic [ACC_W-1:0] sum_ed,
    output logic [2*W-1:0]   max_ed,
    output logic             busy,
    output logic             sat
);

    localparam int SW = ACC_W + 1;

    state_e           state_q, state_d;
    logic [2*W-1:0]   p_q;
    logic [CNT_W-1:0] ns_q, ns_d;
    logic [CNT_W-1:0] ne_q, ne_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [2*W-1:0]   mx_q, mx_d;
    logic             sat_q, sat_d;
    logic             start;
    logic             done;
    logic [2*W-1:0]   exact;
    logic [2*W-1:0]   ed;
    logic [SW-1:0]    sum_ext;

    assign in_ready = (state_q == ST_IDLE) && !clear;
    assign start    = in_valid && in_ready;
    assign busy     = (state_q != ST_IDLE);

    booth_r4_seq_mult #(.W(W)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .x       (in_x),
        .y       (in_y),
        .done    (done),
        .product (exact)
    );

    assign ed      = (exact >= p_q) ? (exact - p_q) : (p_q - exact);
    assign sum_ext = {1'b0, sum_q} + SW'(ed);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_MUL;
            ST_MUL:  if (done)  state_d = ST_CMP;
            ST_CMP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d = ST_IDLE;
        end
    end

    // counters stick at all-ones; the overflowing update raises sat
    always_comb begin
        ns_d  = ns_q;
        ne_d  = ne_q;
        sum_d = sum_q;
        mx_d  = mx_q;
        sat_d = sat_q;
        if (clear) begin
            ns_d  = '0;
            ne_d  = '0;
            sum_d = '0;
            mx_d  = '0;
            sat_d = 1'b0;
        end else if (state_q == ST_CMP) begin
            if (&ns_q) sat_d = 1'b1;
            else       ns_d  = ns_q + CNT_W'(1);
            if (ed != '0) begin
                if (&ne_q) sat_d = 1'b1;
                else       ne_d  = ne_q + CNT_W'(1);
            end
            if (sum_ext[ACC_W]) begin
                sum_d = '1;
                sat_d = 1'b1;
            end else begin
                sum_d = sum_ext[ACC_W-1:0];
            end
            if (ed > mx_q) mx_d = ed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            ns_q    <= '0;
            ne_q    <= '0;
            sum_q   <= '0;
            mx_q    <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) p_q <= in_p;
            ns_q    <= ns_d;
            ne_q    <= ne_d;
            sum_q   <= sum_d;
            mx_q    <= mx_d;
            sat_q   <= sat_d;
        end
    end

    assign n_samples = ns_q;
    assign n_err     = ne_q;
    assign sum_ed    = sum_q;
    assign max_ed    = mx_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Randomized bench for approx_err_monitor against an arithmetic model;
// a CNT_W=4 twin shares the stimulus to exercise saturation.
module tb_approx_err_monitor;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic [W-1:0]  in_x;
    logic [W-1:0]  in_y;
    logic [2*W-1:0] in_p;

    logic          in_ready, busy, sat;
    logic [15:0]   n_samples, n_err;
    logic [31:0]   sum_ed;
    logic [15:0]   max_ed;

    logic          in_ready4, busy4, sat4;
    logic [3:0]    n_samples4, n_err4;
    logic [31:0]   sum_ed4;
    logic [15:0]   max_ed4;

    int n_cmp = 0;
    int n_bad = 0;

    longint m_n, m_err, m_sum, m_max;

    always #5 clk = ~clk;

    approx_err_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_p(in_p),
        .n_samples(n_samples), .n_err(n_err),
        .sum_ed(sum_ed), .max_ed(max_ed),
        .busy(busy), .sat(sat)
    );

    approx_err_monitor #(.CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_x(in_x), .in_y(in_y), .in_p(in_p),
        .n_samples(n_samples4), .n_err(n_err4),
        .sum_ed(sum_ed4), .max_ed(max_ed4),
        .busy(busy4), .sat(sat4)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint cap(input longint v, input int b);
        longint mx;
        mx = (longint'(1) << b) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic longint msat(input int b);
        longint mx;
        mx = (longint'(1) << b) - 1;
        return (m_n > mx || m_err > mx || m_sum > 64'hFFFF_FFFF) ? 1 : 0;
    endfunction

    task automatic model_clear();
        m_n = 0; m_err = 0; m_sum = 0; m_max = 0;
    endtask

    task automatic model(input longint x, input longint y, input longint p);
        longint ex, ed;
        ex = x * y;
        ed = (ex >= p) ? ex - p : p - ex;
        m_n++;
        if (ed != 0) m_err++;
        m_sum += ed;
        if (ed > m_max) m_max = ed;
    endtask

    task automatic check_stats(input string tag);
        chk({tag, ".n"},    n_samples, cap(m_n, 16));
        chk({tag, ".err"},  n_err,     cap(m_err, 16));
        chk({tag, ".sum"},  sum_ed,    cap(m_sum, 32));
        chk({tag, ".max"},  max_ed,    m_max);
        chk({tag, ".sat"},  sat,       msat(16));
        chk({tag, ".n4"},   n_samples4, cap(m_n, 4));
        chk({tag, ".err4"}, n_err4,    cap(m_err, 4));
        chk({tag, ".sum4"}, sum_ed4,   cap(m_sum, 32));
        chk({tag, ".max4"}, max_ed4,   m_max);
        chk({tag, ".sat4"}, sat4,      msat(4));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] p);
        int t;
        t = 0;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        chk("acc.rdy", in_ready, 1);
        in_x = x; in_y = y; in_p = p;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_x = 8'($urandom);
        in_y = 8'($urandom);
        in_p = 16'($urandom);
    endtask

    task automatic do_sample(input logic [7:0] x, input logic [7:0] y,
                             input logic [15:0] p);
        accept(x, y, p);
        chk("smp.busy", busy, 1);
        chk("smp.rdy0", in_ready, 0);
        repeat (5) step();
        check_stats("smp.pre");
        step();
        model(x, y, p);
        check_stats("smp");
        chk("smp.idle", busy, 0);
        chk("smp.rdy1", in_ready, 1);
    endtask

    initial begin
        logic [7:0]  bx[3];
        logic [7:0]  by[3];
        logic [15:0] bp[3];
        logic [7:0]  rx, ry;
        logic [15:0] ex, rp;

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_x = '0; in_y = '0; in_p = '0;
        model_clear();
        repeat (3) step();
        check_stats("rst");
        chk("rst.busy", busy, 0);
        rst_n = 1'b1;
        step();
        chk("rst.rdy", in_ready, 1);

        do_sample(8'd12, 8'd10, 16'd120);
        chk("exact.err", n_err, 0);
        do_sample(8'd255, 8'd255, 16'd65000);
        chk("under.max", max_ed, 25);
        do_sample(8'd3, 8'd3, 16'd13);
        chk("over.sum", sum_ed, 29);
        chk("over.max", max_ed, 25);
        chk("over.n", n_samples, 2 + 1);

        for (int i = 0; i < 3; i++) begin
            bx[i] = 8'($urandom);
            by[i] = 8'($urandom);
            bp[i] = 16'($urandom);
        end
        in_valid = 1'b1;
        for (int c = 0; c < 21; c++) begin
            if (c % 7 == 0) begin
                in_x = bx[c / 7]; in_y = by[c / 7]; in_p = bp[c / 7];
                chk("b2b.rdy1", in_ready, 1);
            end else begin
                in_x = 8'($urandom); in_y = 8'($urandom);
                in_p = 16'($urandom);
                chk("b2b.rdy0", in_ready, 0);
            end
            step();
            if (c % 7 == 6) model(bx[c / 7], by[c / 7], bp[c / 7]);
            check_stats("b2b");
        end
        in_valid = 1'b0;
        chk("b2b.n", n_samples, 6);

        accept(8'd200, 8'd100, 16'd1);
        step();
        step();
        clear = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("clr.rdy", in_ready, 0);
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        model_clear();
        check_stats("clr");
        chk("clr.busy", busy, 0);
        clear = 1'b1;
        in_valid = 1'b1;
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr.noacc", busy, 0);
        repeat (8) step();
        check_stats("clr.post");

        for (int i = 0; i < 20; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            ex = 16'(rx * ry);
            case ($urandom_range(0, 2))
                0: rp = ex;
                1: rp = (ex > 16'd300) ? ex - 16'($urandom_range(0, 300))
                                       : ex + 16'($urandom_range(0, 300));
                default: rp = 16'($urandom);
            endcase
            do_sample(rx, ry, rp);
        end

        clear = 1'b1;
        step();
        clear = 1'b0;
        model_clear();
        check_stats("clr2");
        for (int i = 0; i < 17; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            ex = 16'(rx * ry);
            rp = ex ^ 16'($urandom_range(1, 255));
            do_sample(rx, ry, rp);
        end
        chk("sat.n4", n_samples4, 15);
        chk("sat.err4", n_err4, 15);
        chk("sat.flag4", sat4, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_clear();
        chk("sat.clr4", sat4, 0);
        check_stats("sat.clr");

        do_sample(8'd7, 8'd9, 16'd60);
        accept(8'd99, 8'd77, 16'd5);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_stats("arst");
        chk("arst.busy", busy, 0);
        #2;
        rst_n = 1'b1;
        step();
        chk("arst.rdy", in_ready, 1);
        do_sample(8'd0, 8'd200, 16'd0);
        chk("arst.n", n_samples, 1);
        chk("arst.err", n_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
